// File: rtl/fft_pkg.sv
// Shared types and butterfly address helper for the radix-2 DIT FFT stage AGU.
// Types are sized for the largest legal transform (LOG2N = 12); users take the low bits.
package fft_pkg;

    localparam int FFT_LOG2N_MAX = 12;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        GAP,
        FLUSH,
        DONE
    } fft_agu_state_e;

    typedef logic [FFT_LOG2N_MAX-1:0] addr_t;
    typedef logic [FFT_LOG2N_MAX-2:0] twidx_t;

    typedef struct packed {
        addr_t  a;
        addr_t  b;
        twidx_t twid;
    } bfly_t;

    // Butterfly k of stage s: top/bottom leg addresses and twiddle ROM index.
    function automatic bfly_t bfly_addr(input int log2n, input int s, input int k);
        int    half;
        int    idx;
        int    a;
        bfly_t r;
        half   = 1 << s;
        idx    = k & (half - 1);
        a      = ((k >> s) << (s + 1)) + idx;
        r.a    = addr_t'(a);
        r.b    = addr_t'(a + half);
        r.twid = twidx_t'(idx << (log2n - 1 - s));
        return r;
    endfunction

endpackage

// File: rtl/fft_stage_agu_if.sv
// Control/address bus between the FFT stage AGU (master) and the sample memory,
// twiddle ROM and sequencer (slave).
interface fft_stage_agu_if #(
    parameter int LOG2N = 10
);
    localparam int ADDR_W  = LOG2N;
    localparam int STAGE_W = $clog2(LOG2N);

    logic               start_i;
    logic               busy_o;
    logic               done_o;
    logic [STAGE_W-1:0] stage_o;
    logic               rd_en_o;
    logic [ADDR_W-1:0]  rd_addr_a_o;
    logic [ADDR_W-1:0]  rd_addr_b_o;
    logic [LOG2N-2:0]   twid_idx_o;
    logic               wr_en_o;
    logic [ADDR_W-1:0]  wr_addr_a_o;
    logic [ADDR_W-1:0]  wr_addr_b_o;

    modport master (
        input  start_i,
        output busy_o, done_o, stage_o,
        output rd_en_o, rd_addr_a_o, rd_addr_b_o, twid_idx_o,
        output wr_en_o, wr_addr_a_o, wr_addr_b_o
    );

    modport slave (
        output start_i,
        input  busy_o, done_o, stage_o,
        input  rd_en_o, rd_addr_a_o, rd_addr_b_o, twid_idx_o,
        input  wr_en_o, wr_addr_a_o, wr_addr_b_o
    );
endinterface

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with synchronous clear; aligns read strobes/addresses
// with the write-back of the combinational butterfly.
module fft_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
            logic [WIDTH-1:0] tap_q;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk_i) begin
                    if (rst_i) tap_q <= '0;
                    else       tap_q <= din_i;
                end
            end else begin : g_body
                always_ff @(posedge clk_i) begin
                    if (rst_i) tap_q <= '0;
                    else       tap_q <= g_tap[gi-1].tap_q;
                end
            end
        end
    endgenerate

    assign dout_o = g_tap[DEPTH-1].tap_q;
endmodule

// File: rtl/fft_stage_agu.sv
// In-place radix-2 DIT FFT address generator: one butterfly read per RUN cycle, write-back
// RD_LAT cycles later. Define FFT_AGU_HAZARD_GUARD_EN to insert an RD_LAT-cycle gap between stages.
module fft_stage_agu
    import fft_pkg::*;
#(
    parameter int LOG2N  = 10,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = LOG2N
) (
    input  logic            clk_i,
    input  logic            rst_i,
    fft_stage_agu_if.master bus
);
    localparam int HALF_W  = LOG2N - 1;
    localparam int STAGE_W = $clog2(LOG2N);
    localparam int CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int DL_W    = 1 + 2 * ADDR_W;

    fft_agu_state_e     state_q, state_d;
    logic [STAGE_W-1:0] s_q, s_d;
    logic [HALF_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [ADDR_W-1:0]  rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [LOG2N-2:0]   twid_q, twid_d;

    logic               last_k, last_s, cnt_done;
    bfly_t              bf;
    logic               unused_bf;
    logic [DL_W-1:0]    wr_bus;

    assign last_k    = &k_q;
    assign last_s    = (s_q == STAGE_W'(LOG2N - 1));
    assign cnt_done  = (cnt_q == CNT_W'(RD_LAT - 1));
    assign unused_bf = ^bf;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            stage_q <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            twid_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            stage_q <= stage_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            twid_q  <= twid_d;
        end
    end

    // s/k always name the butterfly being presented on the read port while in RUN.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = RUN;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            RUN: begin
                if (!last_k) begin
                    k_d = k_q + 1'b1;
                end else if (last_s) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    s_d = s_q + 1'b1;
                    k_d = '0;
`ifdef FFT_AGU_HAZARD_GUARD_EN
                    state_d = GAP;
                    cnt_d   = '0;
`endif
                end
            end
            GAP, FLUSH: begin
                if (cnt_done) state_d = (state_q == GAP) ? RUN : DONE;
                else          cnt_d   = cnt_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                s_d     = '0;
                k_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_comb begin
        bf      = bfly_addr(LOG2N, int'(s_d), int'(k_d));
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        rd_en_d = (state_d == RUN);
        stage_d = s_d;
        rd_a_d  = '0;
        rd_b_d  = '0;
        twid_d  = '0;
        if (rd_en_d) begin
            rd_a_d = bf.a[ADDR_W-1:0];
            rd_b_d = bf.b[ADDR_W-1:0];
            twid_d = bf.twid[LOG2N-2:0];
        end
    end

    fft_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (RD_LAT)
    ) u_wr_align (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .din_i  ({rd_en_q, rd_a_q, rd_b_q}),
        .dout_o (wr_bus)
    );

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.stage_o     = stage_q;
    assign bus.rd_en_o     = rd_en_q;
    assign bus.rd_addr_a_o = rd_a_q;
    assign bus.rd_addr_b_o = rd_b_q;
    assign bus.twid_idx_o  = twid_q;
    assign bus.wr_en_o     = wr_bus[DL_W-1];
    assign bus.wr_addr_a_o = wr_bus[2*ADDR_W-1:ADDR_W];
    assign bus.wr_addr_b_o = wr_bus[ADDR_W-1:0];
endmodule

// File: tb/tb_fft_stage_agu.sv
// Bench for fft_stage_agu: three configurations checked every cycle against a schedule model
// derived from cycles-since-start; works with or without FFT_AGU_HAZARD_GUARD_EN.
module tb_fft_stage_agu;
    import fft_pkg::*;

`ifdef FFT_AGU_HAZARD_GUARD_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif

    typedef struct packed {
        int on;
        int s;
        int a;
        int b;
        int tw;
    } rd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst3 = 1'b1, rst4 = 1'b1, rst10 = 1'b1;
    int   total = 0, bad = 0;

    fft_stage_agu_if #(.LOG2N(3))  if3 ();
    fft_stage_agu_if #(.LOG2N(4))  if4 ();
    fft_stage_agu_if #(.LOG2N(10)) if10 ();

    fft_stage_agu #(.LOG2N(3),  .RD_LAT(1)) u3  (.clk_i(clk), .rst_i(rst3),  .bus(if3));
    fft_stage_agu #(.LOG2N(4),  .RD_LAT(3)) u4  (.clk_i(clk), .rst_i(rst4),  .bus(if4));
    fft_stage_agu #(.LOG2N(10), .RD_LAT(2)) u10 (.clk_i(clk), .rst_i(rst10), .bus(if10));

    // ---- behavioural model: everything follows from t = cycles since the accepted start ----
    function automatic int stage_len(input int log2n, input int rdlat);
        return (1 << (log2n - 1)) + GUARD * rdlat;
    endfunction

    function automatic int done_cycle(input int log2n, input int rdlat);
        int last_rd;
        last_rd = (log2n - 1) * stage_len(log2n, rdlat) + (1 << (log2n - 1));
        return last_rd + rdlat + 1;
    endfunction

    function automatic rd_t read_at(input int log2n, input int rdlat, input int t);
        rd_t   r;
        bfly_t bf;
        int    u, s, k;
        r = '0;
        if (t >= 1) begin
            u = t - 1;
            s = u / stage_len(log2n, rdlat);
            k = u % stage_len(log2n, rdlat);
            if (s < log2n && k < (1 << (log2n - 1))) begin
                bf   = bfly_addr(log2n, s, k);
                r.on = 1;
                r.s  = s;
                r.a  = int'(bf.a);
                r.b  = int'(bf.b);
                r.tw = int'(bf.twid);
            end
        end
        return r;
    endfunction

    function automatic int next_t(input int t, input logic rst, input logic st, input int d);
        if (rst)     return 0;
        if (t == 0)  return st ? 1 : 0;
        if (t == d)  return 0;
        return t + 1;
    endfunction

    int   t3 = 0, t4 = 0, t10 = 0;
    logic rs3 = 1'b0, rs4 = 1'b0, rs10 = 1'b0;

    always @(posedge clk) begin
        t3   <= next_t(t3,  rst3,  if3.start_i,  done_cycle(3, 1));
        t4   <= next_t(t4,  rst4,  if4.start_i,  done_cycle(4, 3));
        t10  <= next_t(t10, rst10, if10.start_i, done_cycle(10, 2));
        rs3  <= rst3;
        rs4  <= rst4;
        rs10 <= rst10;
    end

    // ---- checking ----
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string nm, input int log2n, input int rdlat, input int t,
                             input logic rseen, input int busy, input int done, input int stage,
                             input int rd, input int a, input int b, input int tw,
                             input int wr, input int wa, input int wb);
        rd_t er, ew;
        int  d;
        d  = done_cycle(log2n, rdlat);
        er = read_at(log2n, rdlat, t);
        ew = read_at(log2n, rdlat, t - rdlat);
        chk({nm, ".busy"},  busy, (t >= 1 && t <= d) ? 1 : 0);
        chk({nm, ".done"},  done, (t == d) ? 1 : 0);
        chk({nm, ".rd_en"}, rd, er.on);
        chk({nm, ".wr_en"}, wr, ew.on);
        if (er.on != 0) begin
            chk({nm, ".stage"}, stage, er.s);
            chk({nm, ".rd_a"},  a, er.a);
            chk({nm, ".rd_b"},  b, er.b);
            chk({nm, ".twid"},  tw, er.tw);
        end
        if (ew.on != 0) begin
            chk({nm, ".wr_a"}, wa, ew.a);
            chk({nm, ".wr_b"}, wb, ew.b);
        end
        if (t == 0 && rseen) begin
            chk({nm, ".rst_stage"}, stage, 0);
            chk({nm, ".rst_rd_a"},  a, 0);
            chk({nm, ".rst_rd_b"},  b, 0);
            chk({nm, ".rst_twid"},  tw, 0);
            chk({nm, ".rst_wr_a"},  wa, 0);
            chk({nm, ".rst_wr_b"},  wb, 0);
        end
    endtask

    // Hand-computed expectations for LOG2N=3, RD_LAT=1 that pin the model itself.
    task automatic pins_u3();
        int a, b, tw;
        a  = int'(if3.rd_addr_a_o);
        b  = int'(if3.rd_addr_b_o);
        tw = int'(if3.twid_idx_o);
`ifdef FFT_AGU_HAZARD_GUARD_EN
        if (t3 == 1)  begin chk("pin.c1.a", a, 0); chk("pin.c1.b", b, 1); chk("pin.c1.tw", tw, 0); end
        if (t3 == 4)  begin chk("pin.c4.a", a, 6); chk("pin.c4.b", b, 7); chk("pin.c4.tw", tw, 0); end
        if (t3 == 6)  begin chk("pin.c6.a", a, 0); chk("pin.c6.b", b, 2); chk("pin.c6.tw", tw, 0); end
        if (t3 == 5 || t3 == 10) chk("pin.gap_rd_en", int'(if3.rd_en_o), 0);
        if (t3 == 15) chk("pin.c15.wr_en", int'(if3.wr_en_o), 1);
        if (t3 == 16) chk("pin.c16.done", int'(if3.done_o), 1);
`else
        if (t3 == 1)  begin chk("pin.c1.a", a, 0); chk("pin.c1.b", b, 1); chk("pin.c1.tw", tw, 0); end
        if (t3 == 4)  begin chk("pin.c4.a", a, 6); chk("pin.c4.b", b, 7); chk("pin.c4.tw", tw, 0); end
        if (t3 == 6)  begin chk("pin.c6.a", a, 1); chk("pin.c6.b", b, 3); chk("pin.c6.tw", tw, 2); end
        if (t3 == 12) begin chk("pin.c12.a", a, 3); chk("pin.c12.b", b, 7); chk("pin.c12.tw", tw, 3); end
        if (t3 == 13) chk("pin.c13.wr_en", int'(if3.wr_en_o), 1);
        if (t3 == 14) chk("pin.c14.done", int'(if3.done_o), 1);
`endif
    endtask

    logic chk_on = 1'b0;
    int   wr4 = 0, reads10 = 0, dup10 = 0, twmax10 = 0, twmin10 = 1 << 20;
    bit   used10 [10][1024];

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check_dut("u3", 3, 1, t3, rs3, int'(if3.busy_o), int'(if3.done_o), int'(if3.stage_o),
                      int'(if3.rd_en_o), int'(if3.rd_addr_a_o), int'(if3.rd_addr_b_o),
                      int'(if3.twid_idx_o), int'(if3.wr_en_o), int'(if3.wr_addr_a_o),
                      int'(if3.wr_addr_b_o));
            check_dut("u4", 4, 3, t4, rs4, int'(if4.busy_o), int'(if4.done_o), int'(if4.stage_o),
                      int'(if4.rd_en_o), int'(if4.rd_addr_a_o), int'(if4.rd_addr_b_o),
                      int'(if4.twid_idx_o), int'(if4.wr_en_o), int'(if4.wr_addr_a_o),
                      int'(if4.wr_addr_b_o));
            check_dut("u10", 10, 2, t10, rs10, int'(if10.busy_o), int'(if10.done_o),
                      int'(if10.stage_o), int'(if10.rd_en_o), int'(if10.rd_addr_a_o),
                      int'(if10.rd_addr_b_o), int'(if10.twid_idx_o), int'(if10.wr_en_o),
                      int'(if10.wr_addr_a_o), int'(if10.wr_addr_b_o));
            pins_u3();
            if (if4.wr_en_o) wr4++;
            if (if10.rd_en_o) begin
                int s, a, b, tw;
                s  = int'(if10.stage_o);
                a  = int'(if10.rd_addr_a_o);
                b  = int'(if10.rd_addr_b_o);
                tw = int'(if10.twid_idx_o);
                reads10++;
                if (tw > twmax10) twmax10 = tw;
                if (tw < twmin10) twmin10 = tw;
                if (s < 10) begin
                    if (used10[s][a] || used10[s][b] || a == b) dup10++;
                    used10[s][a] = 1'b1;
                    used10[s][b] = 1'b1;
                end else begin
                    dup10++;
                end
            end
        end
    end

    // ---- stimulus ----
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int covered;
        if3.start_i  = 1'b0;
        if4.start_i  = 1'b0;
        if10.start_i = 1'b0;
        step();
        chk_on = 1'b1;
        repeat (2) step();
        rst3 = 1'b0; rst4 = 1'b0; rst10 = 1'b0;

        // u3: start held high for a whole transform, dropped in the done cycle
        repeat ($urandom_range(0, 4)) step();
        if3.start_i = 1'b1;
        n = 0;
        do begin step(); n++; end while (t3 != done_cycle(3, 1) && n < 100);
        if3.start_i = 1'b0;
        repeat (2) step();

        // u3: abort with reset at cycle 7, then a fresh run with ignored start pulses
        if3.start_i = 1'b1;
        step();
        if3.start_i = 1'b0;
        n = 0;
        while (t3 != 7 && n < 100) begin step(); n++; end
        rst3 = 1'b1;
        step();
        rst3 = 1'b0;
        repeat ($urandom_range(2, 5)) step();
        if3.start_i = 1'b1;
        step();
        n = 0;
        while (t3 != 0 && n < 100) begin
            if3.start_i = ($urandom_range(0, 2) == 0);
            step();
            n++;
        end
        if3.start_i = 1'b0;
        repeat (3) step();

        // u4: RD_LAT=3 alignment, random ignored starts, count write strobes
        if4.start_i = 1'b1;
        step();
        n = 0;
        while (t4 != 0 && n < 200) begin
            if4.start_i = ($urandom_range(0, 3) == 0);
            step();
            n++;
        end
        if4.start_i = 1'b0;
        repeat (4) step();
        chk("u4.wr_count", wr4, 32);

        // u10: full 1024-point run, scoreboard of per-stage address coverage
        if10.start_i = 1'b1;
        step();
        n = 0;
        while (t10 != 0 && n < 6000) begin
            if10.start_i = ($urandom_range(0, 7) == 0);
            step();
            n++;
        end
        if10.start_i = 1'b0;
        repeat (3) step();
        covered = 0;
        for (int s = 0; s < 10; s++)
            for (int x = 0; x < 1024; x++)
                if (used10[s][x]) covered++;
        chk("u10.reads", reads10, 5120);
        chk("u10.dups", dup10, 0);
        chk("u10.covered", covered, 10240);
        chk("u10.tw_max", twmax10, 511);
        chk("u10.tw_min", twmin10, 0);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
